// File: rtl/arp_pkg.sv
// Shared types and ARP field constants for the ARP receive decoder.
package arp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SHA,
        SPA,
        THA,
        TPA,
        WAIT_END,
        DROP
    } arp_state_t;

    localparam int unsigned ARP_LEN    = 28;
    localparam int unsigned BYTE_CNT_W = 5;

    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OPER_REP   = 16'h0002;
    localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
    localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;

    // Index of the last byte of each field within the payload
    localparam logic [BYTE_CNT_W-1:0] ARP_HTYPE_END = 5'd1;
    localparam logic [BYTE_CNT_W-1:0] ARP_PTYPE_END = 5'd3;
    localparam logic [BYTE_CNT_W-1:0] ARP_HLEN_END  = 5'd4;
    localparam logic [BYTE_CNT_W-1:0] ARP_PLEN_END  = 5'd5;
    localparam logic [BYTE_CNT_W-1:0] ARP_OPER_END  = 5'd7;
    localparam logic [BYTE_CNT_W-1:0] ARP_SHA_END   = 5'd13;
    localparam logic [BYTE_CNT_W-1:0] ARP_SPA_END   = 5'd17;
    localparam logic [BYTE_CNT_W-1:0] ARP_THA_END   = 5'd23;
    localparam logic [BYTE_CNT_W-1:0] ARP_TPA_END   = BYTE_CNT_W'(ARP_LEN - 1);

endpackage

// File: rtl/nibble_pack.sv
// Nibble-to-byte assembler: low nibble first, phase cleared whenever arp_en is low.
module nibble_pack (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arp_en,
    input  logic [3:0] nib,
    input  logic       nib_valid,
    output logic [7:0] byte_c,
    output logic       byte_valid_c
);

    logic       phase;
    logic [3:0] lo_nib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 1'b0;
            lo_nib <= 4'h0;
        end else if (!arp_en) begin
            phase  <= 1'b0;
        end else if (nib_valid) begin
            phase <= ~phase;
            if (!phase) begin
                lo_nib <= nib;
            end
        end
    end

    // Byte completes combinationally on the high nibble so the parser sees it the same cycle
    assign byte_c       = {nib, lo_nib};
    assign byte_valid_c = arp_en & nib_valid & phase;

endmodule

// File: rtl/arp_decode.sv
// ARP payload parser: validates the fixed header, matches TPA to LOCAL_IP and reports
// the sender once the frame ends with good CRC. Define ARP_REPLY_SNOOP_EN to also accept replies.
module arp_decode
    import arp_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0164,
    parameter logic [47:0] LOCAL_MAC = 48'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_en,
    input  logic [3:0]  nib,
    input  logic        nib_valid,
    input  logic        crc_err,
    output logic        req_valid,
    output logic [47:0] req_sha,
    output logic [31:0] req_spa,
    output logic        drop,
    output logic        busy
`ifdef ARP_REPLY_SNOOP_EN
    ,
    output logic        rep_valid,
    output logic [47:0] rep_sha,
    output logic [31:0] rep_spa
`endif
);

    arp_state_t              state;
    arp_state_t              state_nx;
    logic [BYTE_CNT_W-1:0]   byte_cnt;
    logic [7:0]              byte_c;
    logic                    byte_valid_c;
    logic [7:0]              hdr_last;
    logic [47:0]             sha_sh;
    logic [31:0]             spa_sh;
    logic [23:0]             tpa_sr;
    logic [15:0]             field16_c;
    logic [31:0]             tpa_c;
    logic                    req_nx;
    logic                    drop_nx;
`ifdef ARP_REPLY_SNOOP_EN
    logic                    is_rep;
    logic                    rep_nx;
`endif

    nibble_pack u_pack (
        .clk          (clk),
        .rst_n        (rst_n),
        .arp_en       (arp_en),
        .nib          (nib),
        .nib_valid    (nib_valid),
        .byte_c       (byte_c),
        .byte_valid_c (byte_valid_c)
    );

    assign field16_c = {hdr_last, byte_c};
    assign tpa_c     = {tpa_sr, byte_c};

    // Next-state and pulse decode
    always_comb begin
        state_nx = state;
        req_nx   = 1'b0;
        drop_nx  = 1'b0;
`ifdef ARP_REPLY_SNOOP_EN
        rep_nx   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (arp_en && nib_valid) begin
                    state_nx = HDR;
                end
            end
            HDR, SHA, SPA, THA, TPA: begin
                if (!arp_en) begin
                    drop_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (byte_valid_c) begin
                    case (byte_cnt)
                        ARP_HTYPE_END: if (field16_c != ARP_HTYPE_ETH)  state_nx = DROP;
                        ARP_PTYPE_END: if (field16_c != ARP_PTYPE_IPV4) state_nx = DROP;
                        ARP_HLEN_END:  if (byte_c != ARP_HLEN_ETH)      state_nx = DROP;
                        ARP_PLEN_END:  if (byte_c != ARP_PLEN_IPV4)     state_nx = DROP;
                        ARP_OPER_END: begin
                            if (field16_c == ARP_OPER_REQ) begin
                                state_nx = SHA;
`ifdef ARP_REPLY_SNOOP_EN
                            end else if (field16_c == ARP_OPER_REP) begin
                                state_nx = SHA;
`endif
                            end else begin
                                state_nx = DROP;
                            end
                        end
                        ARP_SHA_END: state_nx = SPA;
                        ARP_SPA_END: state_nx = THA;
                        ARP_THA_END: state_nx = TPA;
                        ARP_TPA_END: state_nx = (tpa_c == LOCAL_IP) ? WAIT_END : DROP;
                        default: ;
                    endcase
                end
            end
            WAIT_END: begin
                if (!arp_en) begin
                    state_nx = IDLE;
                    if (crc_err) begin
                        drop_nx = 1'b1;
`ifdef ARP_REPLY_SNOOP_EN
                    end else if (is_rep) begin
                        rep_nx = 1'b1;
`endif
                    end else begin
                        req_nx = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!arp_en) begin
                    drop_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            hdr_last  <= 8'h0;
            sha_sh    <= 48'h0;
            spa_sh    <= 32'h0;
            tpa_sr    <= 24'h0;
            req_valid <= 1'b0;
            req_sha   <= 48'h0;
            req_spa   <= 32'h0;
            drop      <= 1'b0;
            busy      <= 1'b0;
`ifdef ARP_REPLY_SNOOP_EN
            is_rep    <= 1'b0;
            rep_valid <= 1'b0;
            rep_sha   <= 48'h0;
            rep_spa   <= 32'h0;
`endif
        end else begin
            state     <= state_nx;
            req_valid <= req_nx;
            drop      <= drop_nx;
            busy      <= (state_nx != IDLE);

            if (state_nx == IDLE) begin
                byte_cnt <= '0;
            end else if (byte_valid_c && (state inside {HDR, SHA, SPA, THA, TPA})) begin
                byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            end

            // Field shift registers, MSB byte first
            if (byte_valid_c) begin
                hdr_last <= byte_c;
                if (state == SHA) sha_sh <= {sha_sh[39:0], byte_c};
                if (state == SPA) spa_sh <= {spa_sh[23:0], byte_c};
                if (state == TPA) tpa_sr <= {tpa_sr[15:0], byte_c};
            end

            if (req_nx) begin
                req_sha <= sha_sh;
                req_spa <= spa_sh;
            end
`ifdef ARP_REPLY_SNOOP_EN
            if (state == HDR && byte_valid_c && byte_cnt == ARP_OPER_END) begin
                is_rep <= (field16_c == ARP_OPER_REP);
            end
            rep_valid <= rep_nx;
            if (rep_nx) begin
                rep_sha <= sha_sh;
                rep_spa <= spa_sh;
            end
`endif
        end
    end

endmodule

// File: tb/tb_arp_decode.sv
// Directed, table-driven bench for arp_decode: frames with hand-computed outcomes.
module tb_arp_decode;

    localparam logic [31:0] LOCAL_IP = 32'hC0A8_0164;
`ifdef ARP_REPLY_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arp_en = 1'b0;
    logic [3:0]  nib = 4'h0;
    logic        nib_valid = 1'b0;
    logic        crc_err = 1'b0;
    logic        req_valid;
    logic [47:0] req_sha;
    logic [31:0] req_spa;
    logic        drop;
    logic        busy;
`ifdef ARP_REPLY_SNOOP_EN
    logic        rep_valid;
    logic [47:0] rep_sha;
    logic [31:0] rep_spa;
`endif

    arp_decode #(.LOCAL_IP(LOCAL_IP), .LOCAL_MAC(48'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arp_en    (arp_en),
        .nib       (nib),
        .nib_valid (nib_valid),
        .crc_err   (crc_err),
        .req_valid (req_valid),
        .req_sha   (req_sha),
        .req_spa   (req_spa),
        .drop      (drop),
        .busy      (busy)
`ifdef ARP_REPLY_SNOOP_EN
        ,
        .rep_valid (rep_valid),
        .rep_sha   (rep_sha),
        .rep_spa   (rep_spa)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [31:0] tpa;
        logic [15:0] oper;
        logic        crc;
        int          trunc;
        int          bad_byte;
        logic        stall;
        logic        exp_req;
        logic        exp_drop;
        logic        exp_rep;
    } vec_t;

    int          checks = 0;
    int          passed = 0;
    logic [7:0]  frame [32];
    logic        seen_pulse;
    logic [47:0] model_sha = 48'h0;
    logic [31:0] model_spa = 32'h0;
    logic [47:0] model_rsha = 48'h0;
    logic [31:0] model_rspa = 32'h0;
    vec_t        vecs [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input string name, input logic [47:0] sha, input logic [31:0] spa,
                                input logic [31:0] tpa, input logic [15:0] oper, input logic crc,
                                input int trunc, input int bad_byte, input logic stall,
                                input logic exp_req, input logic exp_drop, input logic exp_rep);
        vec_t v;
        v.name = name; v.sha = sha; v.spa = spa; v.tpa = tpa; v.oper = oper; v.crc = crc;
        v.trunc = trunc; v.bad_byte = bad_byte; v.stall = stall;
        v.exp_req = exp_req; v.exp_drop = exp_drop; v.exp_rep = exp_rep;
        return v;
    endfunction

    task automatic build(input vec_t v);
        frame[0] = 8'h00; frame[1] = 8'h01; frame[2] = 8'h08; frame[3] = 8'h00;
        frame[4] = 8'h06; frame[5] = 8'h04;
        frame[6] = v.oper[15:8]; frame[7] = v.oper[7:0];
        for (int i = 0; i < 6; i++) frame[8+i]  = v.sha[47-8*i -: 8];
        for (int i = 0; i < 4; i++) frame[14+i] = v.spa[31-8*i -: 8];
        for (int i = 0; i < 6; i++) frame[18+i] = 8'(8'h10 + i);
        for (int i = 0; i < 4; i++) frame[24+i] = v.tpa[31-8*i -: 8];
        frame[28] = 8'hA5; frame[29] = 8'h5A; frame[30] = 8'hC3; frame[31] = 8'h3C;
        if (v.bad_byte >= 0) frame[v.bad_byte] = frame[v.bad_byte] ^ 8'hFF;
    endtask

    task automatic watch_pulse();
        if (req_valid || drop) seen_pulse = 1'b1;
`ifdef ARP_REPLY_SNOOP_EN
        if (rep_valid) seen_pulse = 1'b1;
`endif
    endtask

    task automatic send_nib(input logic [3:0] n);
        arp_en = 1'b1; nib_valid = 1'b1; nib = n;
        @(negedge clk);
        watch_pulse();
    endtask

    task automatic stall_cyc();
        nib_valid = 1'b0;
        @(negedge clk);
        watch_pulse();
    endtask

    task automatic send_bytes(input int nbytes, input logic stall);
        for (int b = 0; b < nbytes; b++) begin
            send_nib(frame[b][3:0]);
            if (stall) stall_cyc();
            send_nib(frame[b][7:4]);
            if (stall) stall_cyc();
        end
    endtask

    task automatic run_vec(input vec_t v);
        build(v);
        seen_pulse = 1'b0;
        send_bytes((v.trunc > 0) ? v.trunc : 32, v.stall);
        check({v.name, " busy in frame"}, 64'(busy), 64'(1));
        check({v.name, " no early pulse"}, 64'(seen_pulse), 64'(0));
        arp_en = 1'b0; nib_valid = 1'b0; crc_err = v.crc;
        @(negedge clk);
        if (v.exp_req) begin model_sha = v.sha; model_spa = v.spa; end
        check({v.name, " req_valid"}, 64'(req_valid), 64'(v.exp_req));
        check({v.name, " drop"}, 64'(drop), 64'(v.exp_drop));
        check({v.name, " busy after"}, 64'(busy), 64'(0));
        check({v.name, " req_sha"}, 64'(req_sha), 64'(model_sha));
        check({v.name, " req_spa"}, 64'(req_spa), 64'(model_spa));
`ifdef ARP_REPLY_SNOOP_EN
        if (v.exp_rep) begin model_rsha = v.sha; model_rspa = v.spa; end
        check({v.name, " rep_valid"}, 64'(rep_valid), 64'(v.exp_rep));
        check({v.name, " rep_sha"}, 64'(rep_sha), 64'(model_rsha));
        check({v.name, " rep_spa"}, 64'(rep_spa), 64'(model_rspa));
`endif
        crc_err = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk("t1_good",   48'h020000000001, 32'hC0A8010A, LOCAL_IP,     16'h0001, 1'b0, 0,  -1, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("t2_tpa",    48'h020000000001, 32'hC0A8010A, 32'hC0A80163, 16'h0001, 1'b0, 0,  -1, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("t3_crc",    48'h0200000000AA, 32'hC0A801AA, LOCAL_IP,     16'h0001, 1'b1, 0,  -1, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("t4_trunc",  48'h0200000000BB, 32'hC0A801BB, LOCAL_IP,     16'h0001, 1'b0, 16, -1, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("t4_after",  48'h020000000002, 32'hC0A8010B, LOCAL_IP,     16'h0001, 1'b0, 0,  -1, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("t5_stall",  48'h020000000003, 32'hC0A8010C, LOCAL_IP,     16'h0001, 1'b0, 0,  -1, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("t6_oper2",  48'h020000000004, 32'hC0A8010D, LOCAL_IP,     16'h0002, 1'b0, 0,  -1, 1'b0, 1'b0, !SNOOP, SNOOP));
        vecs.push_back(mk("bad_htype", 48'h020000000005, 32'hC0A8010E, LOCAL_IP,     16'h0001, 1'b0, 0,  1,  1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("bad_ptype", 48'h020000000006, 32'hC0A8010F, LOCAL_IP,     16'h0001, 1'b0, 0,  2,  1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("bad_hlen",  48'h020000000007, 32'hC0A80110, LOCAL_IP,     16'h0001, 1'b0, 0,  4,  1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("bad_plen",  48'h020000000008, 32'hC0A80111, LOCAL_IP,     16'h0001, 1'b0, 0,  5,  1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("bad_oper",  48'h020000000009, 32'hC0A80112, LOCAL_IP,     16'h0001, 1'b0, 0,  7,  1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("trunc_hdr", 48'h02000000000C, 32'hC0A80113, LOCAL_IP,     16'h0001, 1'b0, 3,  -1, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("good_end",  48'h0A1B2C3D4E5F, 32'h0A000001, LOCAL_IP,     16'h0001, 1'b0, 0,  -1, 1'b1, 1'b1, 1'b0, 1'b0));

        // Reset values
        repeat (2) @(negedge clk);
        check("reset req_valid", 64'(req_valid), 64'(0));
        check("reset drop", 64'(drop), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset req_sha", 64'(req_sha), 64'(0));
        check("reset req_spa", 64'(req_spa), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Frames run back to back: arp_en is low for exactly one cycle between them
        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset mid-frame aborts without any pulse and clears the outputs
        build(vecs[0]);
        send_bytes(10, 1'b0);
        rst_n = 1'b0; arp_en = 1'b0; nib_valid = 1'b0;
        @(negedge clk);
        check("midrst req_valid", 64'(req_valid), 64'(0));
        check("midrst drop", 64'(drop), 64'(0));
        check("midrst busy", 64'(busy), 64'(0));
        check("midrst req_sha", 64'(req_sha), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst req_valid", 64'(req_valid), 64'(0));
        check("post-rst drop", 64'(drop), 64'(0));
        model_sha = 48'h0; model_spa = 32'h0;
        model_rsha = 48'h0; model_rspa = 32'h0;
        run_vec(vecs[0]);

        // Pulse lasts one cycle when the line stays idle
        @(negedge clk);
        check("idle req_valid clear", 64'(req_valid), 64'(0));
        check("idle drop clear", 64'(drop), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
